// File: rtl/shift_reg_pkg.sv
// Shared constants and helpers for the shift_reg_n serial-to-parallel register.
package shift_reg_pkg;

   localparam bit SHIFT_DIR_RIGHT = 1'b1;
   localparam bit SHIFT_DIR_LEFT  = 1'b0;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/shift_reg_cnt.sv
// Saturating count of bits shifted in since reset, with a registered full flag.
module shift_reg_cnt
   import shift_reg_pkg::*;
#(
   parameter int n = 5
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    inc,
   output logic [cnt_width(n)-1:0] bit_cnt,
   output logic                    full
);

   localparam int            CW      = cnt_width(n);
   localparam logic [CW-1:0] CNT_MAX = CW'(n);

   logic [CW-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = bit_cnt;
      if (inc && (bit_cnt != CNT_MAX)) begin
         cnt_nxt = bit_cnt + CW'(1);
      end
   end

   // full tracks the next count so it rises on the same edge bit_cnt reaches n
   always_ff @(posedge clk) begin
      if (rstn) begin
         bit_cnt <= '0;
         full    <= 1'b0;
      end else begin
         bit_cnt <= cnt_nxt;
         full    <= (cnt_nxt == CNT_MAX);
      end
   end

endmodule

// File: rtl/shift_reg_n.sv
// n-bit serial-in/parallel-out shift register with bit count and full flag.
// Optional registered parity output enabled by SHIFT_REG_N_PARITY_EN.
module shift_reg_n
   import shift_reg_pkg::*;
#(
   parameter int n           = 5,
   parameter bit SHIFT_RIGHT = SHIFT_DIR_RIGHT
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    data_in,
   input  logic                    shift_en,
   output logic [n-1:0]            data_out,
   output logic [cnt_width(n)-1:0] bit_cnt,
`ifdef SHIFT_REG_N_PARITY_EN
   output logic                    parity,
`endif
   output logic                    full
);

   logic [n-1:0] data_nxt;

   always_comb begin
      data_nxt = data_out;
      if (shift_en) begin
         if (SHIFT_RIGHT == SHIFT_DIR_LEFT) begin
            data_nxt = {data_out[n-2:0], data_in};
         end else begin
            data_nxt = {data_in, data_out[n-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         data_out <= '0;
      end else begin
         data_out <= data_nxt;
      end
   end

`ifdef SHIFT_REG_N_PARITY_EN
   // Parity of the next word so it changes on the same edge as data_out
   always_ff @(posedge clk) begin
      if (rstn) begin
         parity <= 1'b0;
      end else begin
         parity <= ^data_nxt;
      end
   end
`endif

   shift_reg_cnt #(
      .n (n)
   ) u_cnt (
      .clk     (clk),
      .rstn    (rstn),
      .inc     (shift_en),
      .bit_cnt (bit_cnt),
      .full    (full)
   );

endmodule

// File: tb/tb_shift_reg_n.sv
// Scoreboard bench for shift_reg_n: one right-shifting and one left-shifting instance, n=5.
module tb_shift_reg_n;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       data_in = 1'b0;
   logic       shift_en = 1'b0;

   logic [4:0] data_r, data_l;
   logic [2:0] cnt_r, cnt_l;
   logic       full_r, full_l;
`ifdef SHIFT_REG_N_PARITY_EN
   logic       par_r, par_l;
`endif

   typedef struct {
      logic [4:0] dr;
      logic [4:0] dl;
      logic [2:0] cnt;
      logic       full;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   stim_done = 1'b0;

   always #5 clk = ~clk;

   shift_reg_n #(.n(5), .SHIFT_RIGHT(1'b1)) u_dut_r (
      .clk      (clk),
      .rstn     (rstn),
      .data_in  (data_in),
      .shift_en (shift_en),
      .data_out (data_r),
      .bit_cnt  (cnt_r),
`ifdef SHIFT_REG_N_PARITY_EN
      .parity   (par_r),
`endif
      .full     (full_r)
   );

   shift_reg_n #(.n(5), .SHIFT_RIGHT(1'b0)) u_dut_l (
      .clk      (clk),
      .rstn     (rstn),
      .data_in  (data_in),
      .shift_en (shift_en),
      .data_out (data_l),
      .bit_cnt  (cnt_l),
`ifdef SHIFT_REG_N_PARITY_EN
      .parity   (par_l),
`endif
      .full     (full_l)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of stimulus and queue the response expected after the next edge
   task automatic step(input bit rst, input bit en, input bit din,
                       input logic [4:0] er, input logic [4:0] el,
                       input logic [2:0] ec, input bit ef);
      exp_t e;
      @(negedge clk);
      rstn     = rst;
      shift_en = en;
      data_in  = din;
      e.dr = er; e.dl = el; e.cnt = ec; e.full = ef;
      exp_q.push_back(e);
   endtask

   // Monitor: every edge the DUTs present a new word, compare against the queue head
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("data_r", {3'b0, data_r}, {3'b0, e.dr});
            chk("data_l", {3'b0, data_l}, {3'b0, e.dl});
            chk("cnt_r",  {5'b0, cnt_r},  {5'b0, e.cnt});
            chk("cnt_l",  {5'b0, cnt_l},  {5'b0, e.cnt});
            chk("full_r", {7'b0, full_r}, {7'b0, e.full});
            chk("full_l", {7'b0, full_l}, {7'b0, e.full});
`ifdef SHIFT_REG_N_PARITY_EN
            chk("par_r",  {7'b0, par_r},  {7'b0, ^e.dr});
            chk("par_l",  {7'b0, par_l},  {7'b0, ^e.dl});
`endif
         end
      end
   end

   initial begin
      // reset state, then five ones
      step(1, 0, 0, 5'b00000, 5'b00000, 0, 0);
      step(0, 1, 1, 5'b10000, 5'b00001, 1, 0);
      step(0, 1, 1, 5'b11000, 5'b00011, 2, 0);
      step(0, 1, 1, 5'b11100, 5'b00111, 3, 0);
      step(0, 1, 1, 5'b11110, 5'b01111, 4, 0);
      step(0, 1, 1, 5'b11111, 5'b11111, 5, 1);
      // reset overrides shift; partial words leave no residue
      step(1, 1, 1, 5'b00000, 5'b00000, 0, 0);
      for (int p = 0; p < 5; p++) begin
         step(0, 1, 1, 5'b10000, 5'b00001, 1, 0);
         step(0, 1, 1, 5'b11000, 5'b00011, 2, 0);
         step(0, 1, 1, 5'b11100, 5'b00111, 3, 0);
         step(1, 1, 1, 5'b00000, 5'b00000, 0, 0);
      end
      // serial pattern 1,0,1,1,0
      step(0, 1, 1, 5'b10000, 5'b00001, 1, 0);
      step(0, 1, 0, 5'b01000, 5'b00010, 2, 0);
      step(0, 1, 1, 5'b10100, 5'b00101, 3, 0);
      step(0, 1, 1, 5'b11010, 5'b01011, 4, 0);
      step(0, 1, 0, 5'b01101, 5'b10110, 5, 1);
      // hold with data_in toggling
      step(0, 0, 1, 5'b01101, 5'b10110, 5, 1);
      step(0, 0, 0, 5'b01101, 5'b10110, 5, 1);
      step(0, 0, 1, 5'b01101, 5'b10110, 5, 1);
      step(0, 0, 0, 5'b01101, 5'b10110, 5, 1);
      // saturation: seven ones then a zero
      step(1, 0, 0, 5'b00000, 5'b00000, 0, 0);
      step(0, 1, 1, 5'b10000, 5'b00001, 1, 0);
      step(0, 1, 1, 5'b11000, 5'b00011, 2, 0);
      step(0, 1, 1, 5'b11100, 5'b00111, 3, 0);
      step(0, 1, 1, 5'b11110, 5'b01111, 4, 0);
      step(0, 1, 1, 5'b11111, 5'b11111, 5, 1);
      step(0, 1, 1, 5'b11111, 5'b11111, 5, 1);
      step(0, 1, 1, 5'b11111, 5'b11111, 5, 1);
      step(0, 1, 0, 5'b01111, 5'b11110, 5, 1);
      // reset from the full state
      step(1, 0, 0, 5'b00000, 5'b00000, 0, 0);
      step(0, 0, 1, 5'b00000, 5'b00000, 0, 0);
      stim_done = 1'b1;
   end

   initial begin
      int budget;
      budget = 0;
      wait (stim_done);
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #2;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected words left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation reached %0t, expected completion earlier", $time);
      $fatal(1, "timeout");
   end

endmodule
